// File: rtl/uart_rx_frame_assembler_pkg.sv
// Shared FSM type, default start-of-frame byte and checksum helper for the UART frame assembler.
package uart_rx_frame_assembler_pkg;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHK     = 2'd3
  } state_e;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/uart_rx_frame_assembler_if.sv
// Downstream valid/ready byte stream carrying committed payload with an end-of-packet flag.
interface uart_rx_frame_assembler_if;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_last, output out_valid, input out_ready);
  modport slave  (input out_data, input out_last, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx_frame_assembler_fifo.sv
// Payload FIFO with a speculative write pointer; the reader only sees entries below the commit pointer.
module uart_rx_frame_assembler_fifo #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        wr_en,
  input  logic [8:0]  wr_data,
  input  logic        commit,
  input  logic        rollback,
  input  logic        rd_en,
  output logic [8:0]  rd_data,
  output logic        rd_valid,
  output logic [AW:0] free
);

  localparam logic [AW:0] DEPTH_P = DEPTH[AW:0];

  logic [8:0]  mem [DEPTH];
  logic [AW:0] rd_ptr, wr_spec, wr_commit;
  logic [AW:0] used;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_spec[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr    <= '0;
      wr_spec   <= '0;
      wr_commit <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (rollback)   wr_spec <= wr_commit;
      else if (wr_en) wr_spec <= wr_spec + 1'b1;
      if (commit) wr_commit <= wr_spec;
    end
  end

  // Head is masked while empty so stale or never-written entries cannot leak out.
  assign rd_valid = (rd_ptr != wr_commit);
  assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : 9'd0;
  assign used     = wr_spec - rd_ptr;
  assign free     = DEPTH_P - used;

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// UART frame assembler: parses SOF/LEN/payload/CHK and releases payload downstream only once CHK verifies.
//   state     | meaning
//   S_HUNT    | idle, waiting for the start-of-frame byte
//   S_LEN     | next byte is the payload length
//   S_PAYLOAD | writing payload bytes speculatively into the FIFO
//   S_CHK     | next byte is the checksum; commit or roll back
module uart_rx_frame_assembler
  import uart_rx_frame_assembler_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 64,
  parameter int         MAX_LEN      = 32,
  parameter logic [7:0] SOF_BYTE     = SOF_BYTE_DEFAULT,
  parameter int         TIMEOUT_CLKS = 104160
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_done,
  input  logic                             rx_error,
  uart_rx_frame_assembler_if.master        out_if,
  output logic                             pkt_ok,
  output logic                             pkt_bad,
  output logic                             overflow,
  output logic                             busy
);

  localparam int             AW        = $clog2(FIFO_DEPTH);
  localparam int             TW        = $clog2(TIMEOUT_CLKS);
  localparam int             TMO_M1    = TIMEOUT_CLKS - 1;
  localparam logic [TW-1:0]  TMO_LOAD  = TMO_M1[TW-1:0];
  localparam logic [7:0]     MAX_LEN_B = MAX_LEN[7:0];

  state_e        state, state_nx;
  logic [7:0]    len_cnt, len_nx;
  logic [7:0]    sum, sum_nx;
  logic [TW-1:0] tmo_cnt;
  logic          timeout;
  logic          fifo_wr, commit_s, rollback_s, ok_s, bad_s, ovf_s;
  logic          rd_en, rd_valid;
  logic [8:0]    rd_data;
  logic [AW:0]   fifo_free;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= S_HUNT;
      len_cnt  <= '0;
      sum      <= '0;
      pkt_ok   <= 1'b0;
      pkt_bad  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      len_cnt  <= len_nx;
      sum      <= sum_nx;
      pkt_ok   <= ok_s;
      pkt_bad  <= bad_s;
      overflow <= ovf_s;
    end
  end

  always_comb begin
    state_nx   = state;
    len_nx     = len_cnt;
    sum_nx     = sum;
    fifo_wr    = 1'b0;
    commit_s   = 1'b0;
    rollback_s = 1'b0;
    ok_s       = 1'b0;
    bad_s      = 1'b0;
    ovf_s      = 1'b0;
    // rx_error outranks a coincident rx_done, which outranks the timeout.
    if (rx_error) begin
      state_nx = S_HUNT;
      if (state != S_HUNT) begin
        rollback_s = 1'b1;
        bad_s      = 1'b1;
      end
    end else if (rx_done) begin
      case (state)
        S_HUNT: if (rx_data == SOF_BYTE) state_nx = S_LEN;
        S_LEN: begin
          len_nx = rx_data;
          sum_nx = rx_data;
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            bad_s    = 1'b1;
            state_nx = S_HUNT;
          end else if (32'(fifo_free) < 32'(rx_data)) begin
            ovf_s    = 1'b1;
            state_nx = S_HUNT;
          end else begin
            state_nx = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          fifo_wr = 1'b1;
          sum_nx  = chk_add(sum, rx_data);
          len_nx  = len_cnt - 8'd1;
          if (len_cnt == 8'd1) state_nx = S_CHK;
        end
        S_CHK: begin
          state_nx = S_HUNT;
          if (chk_add(sum, rx_data) == 8'd0) begin
            commit_s = 1'b1;
            ok_s     = 1'b1;
          end else begin
            rollback_s = 1'b1;
            bad_s      = 1'b1;
          end
        end
        default: state_nx = S_HUNT;
      endcase
    end else if (timeout) begin
      rollback_s = 1'b1;
      bad_s      = 1'b1;
      state_nx   = S_HUNT;
    end
  end

  // Inter-byte timer counts down from TIMEOUT_CLKS-1 and fires at terminal count zero.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                                   tmo_cnt <= TMO_LOAD;
    else if (!busy || (rx_done && !rx_error))      tmo_cnt <= TMO_LOAD;
    else if (tmo_cnt != '0)                        tmo_cnt <= tmo_cnt - 1'b1;
  end

  assign timeout = busy && (tmo_cnt == '0);
  assign busy    = (state != S_HUNT);

  uart_rx_frame_assembler_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .arst_n   (arst_n),
    .wr_en    (fifo_wr),
    .wr_data  ({len_cnt == 8'd1, rx_data}),
    .commit   (commit_s),
    .rollback (rollback_s),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .free     (fifo_free)
  );

  assign rd_en            = rd_valid & out_if.out_ready;
  assign out_if.out_valid = rd_valid;
  assign out_if.out_data  = rd_data[7:0];
  assign out_if.out_last  = rd_data[8];

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Scoreboard bench for the UART frame assembler: frame-level reference model feeds expected bytes/events to a monitor.
module tb_uart_rx_frame_assembler;

  localparam int         DEPTH = 64;
  localparam int         MAXL  = 32;
  localparam int         TMO   = 300;
  localparam logic [7:0] SOF   = 8'hA5;
  localparam logic [2:0] EV_OK  = 3'b100;
  localparam logic [2:0] EV_BAD = 3'b010;
  localparam logic [2:0] EV_OVF = 3'b001;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_done = 1'b0;
  logic       rx_error = 1'b0;
  logic       pkt_ok, pkt_bad, overflow, busy;
  logic       rnd_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int bytes_seen = 0;
  int lasts_seen = 0;

  logic [8:0] exp_q[$];
  logic [2:0] evq[$];

  uart_rx_frame_assembler_if sif();

  uart_rx_frame_assembler #(
    .FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL), .SOF_BYTE(SOF), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .arst_n(arst_n), .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .out_if(sif), .pkt_ok(pkt_ok), .pkt_bad(pkt_bad), .overflow(overflow), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h expected=nothing at %0t", name, act, $time);
  endfunction

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) sif.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : monitor
    logic       hold_q;
    logic [8:0] held_q, cur;
    logic [2:0] ev;
    hold_q = 1'b0;
    held_q = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        hold_q = 1'b0;
      end else begin
        cur = {sif.out_last, sif.out_data};
        if (hold_q) begin
          check("hold_valid", 32'(sif.out_valid), 32'(1));
          check("hold_data", 32'(cur), 32'(held_q));
        end
        if (sif.out_valid && sif.out_ready) begin
          bytes_seen++;
          if (sif.out_last) lasts_seen++;
          if (exp_q.size() == 0) unexpected("out_byte", 32'(cur));
          else check("out_byte", 32'(cur), 32'(exp_q.pop_front()));
        end
        hold_q = sif.out_valid && !sif.out_ready;
        held_q = cur;
        ev = {pkt_ok, pkt_bad, overflow};
        if (ev != 3'b000) begin
          if (evq.size() == 0) unexpected("pkt_event", 32'(ev));
          else check("pkt_event", 32'(ev), 32'(evq.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v, input logic rnd);
    @(posedge clk);
    #1;
    rnd_ready     = rnd;
    sif.out_ready = v;
  endtask

  task automatic wait_events();
    int n = 0;
    while (evq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("events_pending", 32'(evq.size()), 32'(0));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || evq.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size() + evq.size()), 32'(0));
  endtask

  // Frame-level reference: outcome decided from length limits, free space and byte sum alone.
  task automatic frame(input logic [7:0] lenb, input bit corrupt, input int maxgap);
    logic [7:0] pl[$];
    int         s;
    logic [7:0] chkb;
    s = int'(lenb);
    for (int i = 0; i < int'(lenb); i++) begin
      pl.push_back(8'($urandom));
      s += int'(pl[i]);
    end
    chkb = 8'(-s);
    if (corrupt) chkb = chkb ^ (8'h01 << $urandom_range(0, 7));
    send_byte(SOF);
    idle($urandom_range(0, maxgap));
    if (lenb == 8'd0 || int'(lenb) > MAXL) begin
      evq.push_back(EV_BAD);
      send_byte(lenb);
      return;
    end
    if (DEPTH - exp_q.size() < int'(lenb)) begin
      evq.push_back(EV_OVF);
      send_byte(lenb);
      return;
    end
    send_byte(lenb);
    for (int i = 0; i < int'(lenb); i++) begin
      idle($urandom_range(0, maxgap));
      send_byte(pl[i]);
    end
    idle($urandom_range(0, maxgap));
    if (!corrupt) begin
      for (int i = 0; i < int'(lenb); i++) exp_q.push_back({i == int'(lenb) - 1, pl[i]});
      evq.push_back(EV_OK);
    end else begin
      evq.push_back(EV_BAD);
    end
    send_byte(chkb);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int n, b0, l0;
    logic [7:0] lenb;
    sif.out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(sif.out_valid), 32'(0));
    check("rst_out_data", 32'(sif.out_data), 32'(0));
    check("rst_out_last", 32'(sif.out_last), 32'(0));
    check("rst_pulses", 32'({pkt_ok, pkt_bad, overflow}), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    idle(3);
    arst_n = 1'b1;
    set_ready(1'b1, 1'b0);

    // Known-good frame; nothing visible until the checksum strobe, then one cycle to out_valid.
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    send_byte(SOF); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("t1_busy", 32'(busy), 32'(1));
    check("t1_prevalid", 32'(sif.out_valid), 32'(0));
    evq.push_back(EV_OK);
    send_byte(8'h97);
    check("t1_pkt_ok", 32'(pkt_ok), 32'(1));
    check("t1_valid", 32'(sif.out_valid), 32'(1));
    check("t1_head", 32'({sif.out_last, sif.out_data}), 32'({1'b0, 8'h11}));
    wait_drain();

    // Bad checksum: rolled back, never offered.
    send_byte(SOF); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    evq.push_back(EV_BAD);
    send_byte(8'h98);
    check("t2_pkt_bad", 32'(pkt_bad), 32'(1));
    check("t2_valid", 32'(sif.out_valid), 32'(0));
    idle(5);
    check("t2_valid_later", 32'(sif.out_valid), 32'(0));
    frame(8'd4, 1'b0, 2);
    wait_drain();

    // Length boundaries.
    send_byte(8'h00);
    send_byte(SOF);
    evq.push_back(EV_BAD);
    send_byte(8'h00);
    check("t3_len0_bad", 32'(pkt_bad), 32'(1));
    check("t3_len0_busy", 32'(busy), 32'(0));
    frame(8'h20, 1'b0, 1);
    wait_drain();
    frame(8'h21, 1'b0, 1);
    wait_drain();
    frame(8'hFF, 1'b0, 1);
    wait_drain();

    // Backpressure fills the FIFO; third max-length frame overflows.
    set_ready(1'b0, 1'b0);
    b0 = bytes_seen;
    l0 = lasts_seen;
    repeat (3) frame(8'h20, 1'b0, 1);
    wait_events();
    check("t4_busy", 32'(busy), 32'(0));
    set_ready(1'b1, 1'b0);
    wait_drain();
    check("t4_bytes", 32'(bytes_seen - b0), 32'(64));
    check("t4_lasts", 32'(lasts_seen - l0), 32'(2));

    // Timeout mid-payload, exact latency from the last strobe.
    evq.push_back(EV_BAD);
    send_byte(SOF); send_byte(8'h03); send_byte(8'h11);
    n = 0;
    while (!pkt_bad && n < TMO + 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_timeout_cycles", 32'(n), 32'(TMO));
    wait_events();
    frame(8'd3, 1'b0, 2);
    wait_drain();
    // Longest gap that must still not time out.
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b1, 8'hC3});
    send_byte(SOF); send_byte(8'h02); send_byte(8'h5A);
    idle(TMO - 2);
    send_byte(8'hC3);
    evq.push_back(EV_OK);
    send_byte(8'hE1);
    wait_drain();

    // rx_error coincident with rx_done mid-payload, held several cycles.
    send_byte(SOF); send_byte(8'h03); send_byte(8'h11);
    evq.push_back(EV_BAD);
    @(negedge clk);
    rx_error = 1'b1; rx_done = 1'b1; rx_data = 8'h22;
    @(negedge clk);
    rx_done = 1'b0;
    check("t6_err_bad", 32'(pkt_bad), 32'(1));
    idle(4);
    check("t6_err_busy", 32'(busy), 32'(0));
    rx_error = 1'b0;
    frame(8'd5, 1'b0, 2);
    wait_drain();

    // Reset mid-frame discards committed-but-unread bytes too.
    set_ready(1'b0, 1'b0);
    frame(8'd5, 1'b0, 1);
    wait_events();
    send_byte(SOF); send_byte(8'h04); send_byte(8'h11);
    check("t7_pre_valid", 32'(sif.out_valid), 32'(1));
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    check("t7_valid", 32'(sif.out_valid), 32'(0));
    check("t7_data", 32'({sif.out_last, sif.out_data}), 32'(0));
    check("t7_pulses", 32'({pkt_ok, pkt_bad, overflow}), 32'(0));
    check("t7_busy", 32'(busy), 32'(0));
    exp_q.delete();
    evq.delete();
    idle(2);
    arst_n = 1'b1;
    set_ready(1'b1, 1'b0);
    idle(4);
    check("t7_post_valid", 32'(sif.out_valid), 32'(0));
    frame(8'd6, 1'b0, 2);
    wait_drain();

    // Randomized frames with random backpressure.
    set_ready(1'b1, 1'b1);
    for (int f = 0; f < 40; f++) begin
      wait_drain();
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 8'hA4)));
      if ($urandom_range(0, 9) == 0) lenb = 8'($urandom_range(0, 255));
      else                           lenb = 8'($urandom_range(1, MAXL));
      frame(lenb, $urandom_range(0, 3) == 0, 4);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
